// File: rtl/instr_dispatch_ctrl_pkg.sv
// Shared opcode classes, sequencer state encoding and unit select for the
// instruction dispatcher.
package instr_dispatch_ctrl_pkg;

    localparam logic [3:0] OPC_NOP    = 4'h0;
    localparam logic [3:0] OPC_HALT   = 4'h7;
    localparam logic [3:0] OPC_RSVD   = 4'h8;
    localparam logic [3:0] OPC_MEM_LO = 4'h1;
    localparam logic [3:0] OPC_MEM_HI = 4'h3;
    localparam logic [3:0] OPC_MOV_LO = 4'h4;
    localparam logic [3:0] OPC_MOV_HI = 4'h6;
    localparam logic [3:0] OPC_ALU_LO = 4'h9;
    localparam logic [3:0] OPC_ALU_HI = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ISSUE,
        WAIT,
        RETIRE,
        HALTED
    } state_t;

    typedef enum logic [1:0] {
        ALU,
        MEM,
        MOV
    } unit_t;

endpackage

// File: rtl/instr_dispatch_ctrl_if.sv
// Instruction handshake plus the start/done/abort bus shared with the
// execution units.
interface instr_dispatch_ctrl_if #(
    parameter int IW = 16
);
    logic [IW-1:0] instr_in;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] ir_out;
    logic          alu_start;
    logic          mem_start;
    logic          mov_start;
    logic          alu_done;
    logic          mem_done;
    logic          mov_done;
    logic          unit_abort;

    modport master (
        input  instr_in, instr_valid, alu_done, mem_done, mov_done,
        output instr_ready, ir_out, alu_start, mem_start, mov_start, unit_abort
    );

    modport slave (
        output instr_in, instr_valid, alu_done, mem_done, mov_done,
        input  instr_ready, ir_out, alu_start, mem_start, mov_start, unit_abort
    );
endinterface

// File: rtl/instr_dispatch_ctrl_opcode_classify.sv
// Combinational opcode decode: selects the execution unit and flags the
// NOP, HALT and reserved opcodes.
module instr_dispatch_ctrl_opcode_classify
    import instr_dispatch_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output unit_t      unit,
    output logic       is_nop,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        unit       = ALU;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (opcode == OPC_NOP) begin
            is_nop = 1'b1;
        end else if (opcode == OPC_HALT) begin
            is_halt = 1'b1;
        end else if (opcode == OPC_RSVD) begin
            is_illegal = 1'b1;
        end else if (opcode >= OPC_MEM_LO && opcode <= OPC_MEM_HI) begin
            unit = MEM;
        end else if (opcode >= OPC_MOV_LO && opcode <= OPC_MOV_HI) begin
            unit = MOV;
        end else if (opcode >= OPC_ALU_LO && opcode <= OPC_ALU_HI) begin
            unit = ALU;
        end
    end

endmodule

// File: rtl/instr_dispatch_ctrl.sv
// Instruction sequencer: latches one instruction, dispatches it to a single
// execution unit, times out hung units and counts retirements.
module instr_dispatch_ctrl
    import instr_dispatch_ctrl_pkg::*;
#(
    parameter int IW      = 16,
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_dispatch_ctrl_if.master bus,
    output logic                 busy,
    output logic                 retired,
    output logic                 illegal,
    output logic                 timeout_err,
    input  logic                 err_clr,
    output logic                 halted,
    input  logic                 resume,
    output logic [CNT_W-1:0]     retire_cnt
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    unit_t      unit_sel;
    logic [7:0] timer;

    unit_t cls_unit;
    logic  cls_nop;
    logic  cls_halt;
    logic  cls_illegal;
    logic  sel_done;

    instr_dispatch_ctrl_opcode_classify u_classify (
        .opcode     (bus.ir_out[IW-1 -: 4]),
        .unit       (cls_unit),
        .is_nop     (cls_nop),
        .is_halt    (cls_halt),
        .is_illegal (cls_illegal)
    );

    // Only the unit that was issued may complete the instruction.
    always_comb begin
        sel_done = 1'b0;
        case (unit_sel)
            ALU:     sel_done = bus.alu_done;
            MEM:     sel_done = bus.mem_done;
            MOV:     sel_done = bus.mov_done;
            default: sel_done = 1'b0;
        endcase
    end

    // Outputs are assigned on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            unit_sel        <= ALU;
            timer           <= '0;
            bus.ir_out      <= '0;
            bus.instr_ready <= 1'b0;
            bus.alu_start   <= 1'b0;
            bus.mem_start   <= 1'b0;
            bus.mov_start   <= 1'b0;
            bus.unit_abort  <= 1'b0;
            busy            <= 1'b0;
            retired         <= 1'b0;
            illegal         <= 1'b0;
            timeout_err     <= 1'b0;
            halted          <= 1'b0;
            retire_cnt      <= '0;
        end else begin
            bus.alu_start  <= 1'b0;
            bus.mem_start  <= 1'b0;
            bus.mov_start  <= 1'b0;
            bus.unit_abort <= 1'b0;
            retired        <= 1'b0;
            illegal        <= 1'b0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        bus.ir_out      <= bus.instr_in;
                        bus.instr_ready <= 1'b0;
                        busy            <= 1'b1;
                        state           <= DECODE;
                    end else begin
                        bus.instr_ready <= 1'b1;
                    end
                end

                DECODE: begin
                    unit_sel <= cls_unit;
                    if (cls_nop || cls_illegal) begin
                        retired    <= 1'b1;
                        illegal    <= cls_illegal;
                        retire_cnt <= retire_cnt + CNT_W'(1);
                        state      <= RETIRE;
                    end else if (cls_halt) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= HALTED;
                    end else begin
                        bus.alu_start <= (cls_unit == ALU);
                        bus.mem_start <= (cls_unit == MEM);
                        bus.mov_start <= (cls_unit == MOV);
                        timer         <= '0;
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    timer <= timer + 8'd1;
                    state <= WAIT;
                end

                // timer holds the number of the current WAIT cycle.
                WAIT: begin
                    if (sel_done) begin
                        retired    <= 1'b1;
                        retire_cnt <= retire_cnt + CNT_W'(1);
                        state      <= RETIRE;
                    end else if (timer == TIMEOUT_CNT) begin
                        bus.unit_abort <= 1'b1;
                        timeout_err    <= 1'b1;
                        retired        <= 1'b1;
                        retire_cnt     <= retire_cnt + CNT_W'(1);
                        state          <= RETIRE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                RETIRE: begin
                    busy            <= 1'b0;
                    bus.instr_ready <= 1'b1;
                    state           <= IDLE;
                end

                HALTED: begin
                    if (resume) begin
                        halted          <= 1'b0;
                        bus.instr_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end

                default: begin
                    busy            <= 1'b0;
                    halted          <= 1'b0;
                    bus.instr_ready <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Directed bench for instr_dispatch_ctrl; a second instance with a narrow
// counter and short timeout covers counter wrap and clear/set collision.
module tb_instr_dispatch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        err_clr, resume, err_clr_w, resume_w;
    logic        busy, retired, illegal, timeout_err, halted;
    logic        busy_w, retired_w, illegal_w, timeout_err_w, halted_w;
    logic [15:0] retire_cnt;
    logic [3:0]  retire_cnt_w;

    int checks = 0;
    int errors = 0;
    int n_a, n_b;

    instr_dispatch_ctrl_if #(.IW(16)) bus ();
    instr_dispatch_ctrl_if #(.IW(16)) bus_w ();

    instr_dispatch_ctrl #(.IW(16), .TIMEOUT(31), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .retired     (retired),
        .illegal     (illegal),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .halted      (halted),
        .resume      (resume),
        .retire_cnt  (retire_cnt)
    );

    instr_dispatch_ctrl #(.IW(16), .TIMEOUT(3), .CNT_W(4)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_w),
        .busy        (busy_w),
        .retired     (retired_w),
        .illegal     (illegal_w),
        .timeout_err (timeout_err_w),
        .err_clr     (err_clr_w),
        .halted      (halted_w),
        .resume      (resume_w),
        .retire_cnt  (retire_cnt_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; err_clr = 1'b0; resume = 1'b0; err_clr_w = 1'b0; resume_w = 1'b0;
        bus.instr_in = '0; bus.instr_valid = 1'b0;
        bus.alu_done = 1'b0; bus.mem_done = 1'b0; bus.mov_done = 1'b0;
        bus_w.instr_in = '0; bus_w.instr_valid = 1'b0;
        bus_w.alu_done = 1'b0; bus_w.mem_done = 1'b0; bus_w.mov_done = 1'b0;

        tick(); tick();
        chk("rst_ready", bus.instr_ready, 0);
        chk("rst_ir", bus.ir_out, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_terr", timeout_err, 0);
        rst = 1'b1;
        tick();
        chk("ready_after_rst", bus.instr_ready, 1);
        chk("idle_busy", busy, 0);

        // ALU dispatch, done 9 cycles after start
        bus.instr_in = 16'h9042; bus.instr_valid = 1'b1;
        tick();                                   // DECODE
        bus.instr_valid = 1'b0; bus.instr_in = 16'h1234;
        chk("alu_dec_ir", bus.ir_out, 16'h9042);
        chk("alu_dec_ready", bus.instr_ready, 0);
        chk("alu_dec_busy", busy, 1);
        tick();                                   // ISSUE
        chk("alu_start", {bus.alu_start, bus.mem_start, bus.mov_start}, 3'b100);
        n_a = 0; n_b = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();                               // WAIT1..8
            n_a += int'(bus.alu_start);
            n_b += int'(bus.mem_start | bus.mov_start | retired);
        end
        chk("alu_single_start", n_a, 0);
        chk("alu_no_other", n_b, 0);
        chk("alu_wait_ir", bus.ir_out, 16'h9042);
        tick();                                   // WAIT9
        bus.alu_done = 1'b1;
        tick();                                   // RETIRE
        bus.alu_done = 1'b0;
        chk("alu_retired", retired, 1);
        chk("alu_cnt", retire_cnt, 1);
        chk("alu_ret_ir", bus.ir_out, 16'h9042);
        chk("alu_abort", bus.unit_abort, 0);
        tick();                                   // IDLE
        chk("alu_idle_retired", retired, 0);
        chk("alu_idle_ready", bus.instr_ready, 1);

        // NOP followed immediately by MOV; alu_done during MOV is ignored
        bus.instr_in = 16'h0000; bus.instr_valid = 1'b1;
        tick();                                   // DECODE (NOP)
        bus.instr_in = 16'h4083;
        chk("nop_dec_ready", bus.instr_ready, 0);
        tick();                                   // RETIRE
        chk("nop_retired", retired, 1);
        chk("nop_cnt", retire_cnt, 2);
        chk("nop_no_start", {bus.alu_start, bus.mem_start, bus.mov_start}, 3'b000);
        tick();                                   // IDLE
        chk("nop_idle_ready", bus.instr_ready, 1);
        tick();                                   // DECODE (MOV)
        bus.instr_valid = 1'b0;
        chk("mov_dec_ir", bus.ir_out, 16'h4083);
        tick();                                   // ISSUE
        chk("mov_start", {bus.alu_start, bus.mem_start, bus.mov_start}, 3'b001);
        bus.alu_done = 1'b1;
        tick();                                   // WAIT1
        chk("mov_wait_start", {bus.alu_start, bus.mem_start, bus.mov_start}, 3'b000);
        tick();                                   // WAIT2
        chk("wrong_done_ignored", {busy, retired}, 2'b10);
        bus.alu_done = 1'b0; bus.mov_done = 1'b1;
        tick();                                   // RETIRE
        bus.mov_done = 1'b0;
        chk("mov_retired", retired, 1);
        chk("mov_cnt", retire_cnt, 3);
        tick();                                   // IDLE

        // MEM timeout
        bus.instr_in = 16'h1000; bus.instr_valid = 1'b1;
        tick();                                   // DECODE
        bus.instr_valid = 1'b0;
        tick();                                   // ISSUE
        chk("mem_start", {bus.alu_start, bus.mem_start, bus.mov_start}, 3'b010);
        n_a = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();                               // WAIT1..31
            n_a += int'(bus.unit_abort);
        end
        chk("to_no_early_abort", n_a, 0);
        chk("to_wait_busy", busy, 1);
        tick();                                   // RETIRE
        chk("to_abort", bus.unit_abort, 1);
        chk("to_err", timeout_err, 1);
        chk("to_retired", retired, 1);
        chk("to_cnt", retire_cnt, 4);
        tick();                                   // IDLE
        chk("to_abort_pulse", bus.unit_abort, 0);
        chk("to_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", timeout_err, 0);

        // done coincides with the timeout limit: done wins
        bus.instr_in = 16'h1000; bus.instr_valid = 1'b1;
        tick();                                   // DECODE
        bus.instr_valid = 1'b0;
        tick();                                   // ISSUE
        for (int i = 1; i <= 31; i++) tick();     // WAIT1..31
        bus.mem_done = 1'b1;
        tick();                                   // RETIRE
        bus.mem_done = 1'b0;
        chk("race_abort", bus.unit_abort, 0);
        chk("race_err", timeout_err, 0);
        chk("race_retired", retired, 1);
        chk("race_cnt", retire_cnt, 5);
        tick();                                   // IDLE

        // reserved opcode
        bus.instr_in = 16'h8000; bus.instr_valid = 1'b1;
        tick();                                   // DECODE
        bus.instr_valid = 1'b0;
        tick();                                   // RETIRE
        chk("ill_pulse", illegal, 1);
        chk("ill_retired", retired, 1);
        chk("ill_cnt", retire_cnt, 6);
        chk("ill_no_start", {bus.alu_start, bus.mem_start, bus.mov_start}, 3'b000);
        tick();                                   // IDLE
        chk("ill_pulse_end", illegal, 0);

        // HALT and resume
        bus.instr_in = 16'h7000; bus.instr_valid = 1'b1;
        tick();                                   // DECODE
        bus.instr_valid = 1'b0;
        tick();                                   // HALTED
        chk("halt_flag", halted, 1);
        chk("halt_ready", bus.instr_ready, 0);
        chk("halt_busy", busy, 0);
        chk("halt_retired", retired, 0);
        chk("halt_cnt", retire_cnt, 6);
        tick();
        chk("halt_stays", halted, 1);
        resume = 1'b1;
        tick();                                   // IDLE
        resume = 1'b0;
        chk("resume_halted", halted, 0);
        chk("resume_ready", bus.instr_ready, 1);

        // reset during WAIT
        bus.instr_in = 16'h9000; bus.instr_valid = 1'b1;
        tick();                                   // DECODE
        bus.instr_valid = 1'b0;
        tick(); tick(); tick();                   // ISSUE, WAIT1, WAIT2
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ir", bus.ir_out, 0);
        chk("rst_mid_cnt", retire_cnt, 0);
        chk("rst_mid_ready", bus.instr_ready, 0);
        tick();
        chk("rst_mid_pulses", {bus.alu_start, bus.mem_start, bus.mov_start,
                               bus.unit_abort, retired, busy}, 6'b0);
        rst = 1'b1;
        tick();
        chk("rst_mid_release", bus.instr_ready, 1);

        // narrow counter wraps after 16 retirements
        bus_w.instr_in = 16'h0000; bus_w.instr_valid = 1'b1;
        for (int i = 1; i <= 44; i++) tick();     // 15th RETIRE
        chk("wrap_pre_cnt", retire_cnt_w, 4'hF);
        chk("wrap_pre_retired", retired_w, 1);
        tick(); tick(); tick();                   // IDLE, DECODE, RETIRE
        bus_w.instr_valid = 1'b0;
        chk("wrap_cnt", retire_cnt_w, 4'h0);
        chk("wrap_retired", retired_w, 1);
        tick();                                   // IDLE

        // err_clr held while a timeout fires: set wins
        bus_w.instr_in = 16'h2000; bus_w.instr_valid = 1'b1; err_clr_w = 1'b1;
        tick();                                   // DECODE
        bus_w.instr_valid = 1'b0;
        tick(); tick(); tick(); tick();           // ISSUE, WAIT1..3
        tick();                                   // RETIRE
        chk("setwins_abort", bus_w.unit_abort, 1);
        chk("setwins_err", timeout_err_w, 1);
        tick();
        chk("setwins_clr_after", timeout_err_w, 0);
        err_clr_w = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
